// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// wb_regfile : write-back register file, 31 x WIDTH storage, X[ZERO_REG] == 0
// Optional macro WB_BYPASS_EN enables same-cycle WB->ID write-through reads.
// Revision   : 1.0
// ============================================================================
module wb_regfile #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             regWrite,
    input  logic [4:0]       wrAddr,
    input  logic [WIDTH-1:0] wrData,
    input  logic [4:0]       rdAddr1,
    input  logic [4:0]       rdAddr2,
    output logic [WIDTH-1:0] rdData1,
    output logic [WIDTH-1:0] rdData2
);

    localparam logic [4:0] ZERO_ADDR = 5'(ZERO_REG);

    logic [WIDTH-1:0] reg_view [32];
    logic             wr_en;

    assign wr_en = regWrite && (wrAddr != ZERO_ADDR);

    // The zero register has no flop at all; its read view is tied low.
    for (genvar i = 0; i < 32; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign reg_view[i] = '0;
        end else begin : g_store
            logic [WIDTH-1:0] q;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    q <= '0;
                end else if (wr_en && (wrAddr == 5'(i))) begin
                    q <= wrData;
                end
            end
            assign reg_view[i] = q;
        end
    end

    logic [WIDTH-1:0] committed1;
    logic [WIDTH-1:0] committed2;

    assign committed1 = reg_view[rdAddr1];
    assign committed2 = reg_view[rdAddr2];

`ifdef WB_BYPASS_EN
    logic hit1;
    logic hit2;

    // wr_en already excludes the zero register, so XZR stays 0 under bypass.
    assign hit1 = reset && wr_en && (wrAddr == rdAddr1);
    assign hit2 = reset && wr_en && (wrAddr == rdAddr2);

    assign rdData1 = !reset ? '0 : (hit1 ? wrData : committed1);
    assign rdData2 = !reset ? '0 : (hit2 ? wrData : committed2);
`else
    assign rdData1 = committed1;
    assign rdData2 = committed2;
`endif

endmodule
`default_nettype wire
